// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared owner encoding and default widths for the SRAM port arbiter
package sram_arb_pkg;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2} owner_t;
endpackage

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: fetch, data, SRAM and stall signals between pipeline, arbiter and SRAM
interface sram_port_arbiter_if #(
   parameter int ADDR_W = sram_arb_pkg::ADDR_W,
   parameter int DATA_W = sram_arb_pkg::DATA_W
);
   logic                  inst_req_en;
   logic [ADDR_W-1:0]     inst_req_addr;
   logic                  inst_flush;
   logic [DATA_W-1:0]     inst_rdata;
   logic                  inst_rvalid;
   logic                  data_req_en;
   logic [DATA_W/8-1:0]   data_we;
   logic [ADDR_W-1:0]     data_addr;
   logic [DATA_W-1:0]     data_wdata;
   logic [DATA_W-1:0]     data_rdata;
   logic                  data_rvalid;
   logic                  sram_en;
   logic [DATA_W/8-1:0]   sram_we;
   logic [ADDR_W-1:0]     sram_addr;
   logic [DATA_W-1:0]     sram_wdata;
   logic [DATA_W-1:0]     sram_rdata;
   logic                  stallreq_if;
   logic                  stallreq_mem;
   modport slave (
      input  inst_req_en, inst_req_addr, inst_flush,
      input  data_req_en, data_we, data_addr, data_wdata,
      input  sram_rdata,
      output inst_rdata, inst_rvalid, data_rdata, data_rvalid,
      output sram_en, sram_we, sram_addr, sram_wdata,
      output stallreq_if, stallreq_mem
   );
   modport master (
      output inst_req_en, inst_req_addr, inst_flush,
      output data_req_en, data_we, data_addr, data_wdata,
      output sram_rdata,
      input  inst_rdata, inst_rvalid, data_rdata, data_rvalid,
      input  sram_en, sram_we, sram_addr, sram_wdata,
      input  stallreq_if, stallreq_mem
   );
endinterface

// File: rtl/sram_arb_perf.sv
// sram_arb_perf: saturating event counters for arbitration conflicts and per-stage stalls
module sram_arb_perf (
   input  logic        clk,
   input  logic        rst,
   input  logic        conflict_i,
   input  logic        if_stall_i,
   input  logic        mem_stall_i,
   output logic [31:0] perf_conflicts_o,
   output logic [31:0] perf_if_stalls_o,
   output logic [31:0] perf_mem_stalls_o
);
   logic [31:0] conflicts_q, if_stalls_q, mem_stalls_q;
   // count each event, sticking at all-ones
   always_ff @(posedge clk) begin
      if (rst) begin
         conflicts_q  <= '0;
         if_stalls_q  <= '0;
         mem_stalls_q <= '0;
      end else begin
         conflicts_q  <= conflicts_q + {31'd0, conflict_i & ~&conflicts_q};
         if_stalls_q  <= if_stalls_q + {31'd0, if_stall_i & ~&if_stalls_q};
         mem_stalls_q <= mem_stalls_q + {31'd0, mem_stall_i & ~&mem_stalls_q};
      end
   end
   assign perf_conflicts_o  = conflicts_q;
   assign perf_if_stalls_o  = if_stalls_q;
   assign perf_mem_stalls_o = mem_stalls_q;
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM between fetch and data with bounded fetch starvation;
// optional perf counters under SRAM_ARB_PERF_EN
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W     = sram_arb_pkg::ADDR_W,
   parameter int DATA_W     = sram_arb_pkg::DATA_W,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   sram_port_arbiter_if.slave  bus
`ifdef SRAM_ARB_PERF_EN
   ,
   output logic [31:0]         perf_conflicts,
   output logic [31:0]         perf_if_stalls,
   output logic [31:0]         perf_mem_stalls
`endif
);
   logic              fetch_act, starve_full, grant_i, grant_d;
   logic [3:0]        starve_q, starve_d;
   owner_t            owner_q, owner_d;
   logic [DATA_W-1:0] inst_rdata_q, data_rdata_q;
   logic              inst_rvalid, data_rvalid;
   // pick one requester, drive the SRAM and compute next owner and starvation count
   always_comb begin
      fetch_act        = bus.inst_req_en & ~bus.inst_flush;
      starve_full      = starve_q == 4'(STARVE_MAX);
      grant_i          = fetch_act & (~bus.data_req_en | starve_full);
      grant_d          = bus.data_req_en & ~grant_i;
      bus.stallreq_if  = fetch_act & ~grant_i;
      bus.stallreq_mem = bus.data_req_en & ~grant_d;
      bus.sram_en      = grant_i | grant_d;
      bus.sram_we      = grant_d ? bus.data_we : '0;
      bus.sram_addr    = grant_i ? bus.inst_req_addr : grant_d ? bus.data_addr : '0;
      bus.sram_wdata   = grant_d ? bus.data_wdata : '0;
      starve_d         = bus.stallreq_if ? (starve_full ? starve_q : starve_q + 4'd1) : 4'd0;
      owner_d          = grant_i ? OWN_I : (grant_d && bus.data_we == '0) ? OWN_D : OWN_NONE;
   end
   // route last cycle's read data to its owner; a late flush kills the fetch return
   always_comb begin
      inst_rvalid     = ~rst & (owner_q == OWN_I) & ~bus.inst_flush;
      data_rvalid     = ~rst & (owner_q == OWN_D);
      bus.inst_rvalid = inst_rvalid;
      bus.data_rvalid = data_rvalid;
      bus.inst_rdata  = inst_rvalid ? bus.sram_rdata : inst_rdata_q;
      bus.data_rdata  = data_rvalid ? bus.sram_rdata : data_rdata_q;
   end
   // track read ownership, fetch starvation and the held return data
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q      <= OWN_NONE;
         starve_q     <= 4'd0;
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
      end else begin
         owner_q      <= owner_d;
         starve_q     <= starve_d;
         inst_rdata_q <= bus.inst_rdata;
         data_rdata_q <= bus.data_rdata;
      end
   end
`ifdef SRAM_ARB_PERF_EN
   sram_arb_perf u_perf (
      .clk               (clk),
      .rst               (rst),
      .conflict_i        (fetch_act & bus.data_req_en),
      .if_stall_i        (bus.stallreq_if),
      .mem_stall_i       (bus.stallreq_mem),
      .perf_conflicts_o  (perf_conflicts),
      .perf_if_stalls_o  (perf_if_stalls),
      .perf_mem_stalls_o (perf_mem_stalls)
   );
`endif
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: vector table plus read-return scoreboard for sram_port_arbiter
module tb_sram_port_arbiter;
   typedef struct {
      logic        rst;
      logic        ie;
      logic [31:0] ia;
      logic        fl;
      logic        de;
      logic [3:0]  we;
      logic [31:0] da;
      logic [1:0]  gnt;
      logic        sif;
      logic        smem;
   } vec_t;
   logic clk, rst;
   int passed, total, confl;
   logic [31:0] iq[$], dq[$];
   logic [31:0] last_i, last_d;
   vec_t vt[$];
   sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
`ifdef SRAM_ARB_PERF_EN
   logic [31:0] pc, pi, pm;
   sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .perf_conflicts(pc), .perf_if_stalls(pi), .perf_mem_stalls(pm));
`else
   sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst), .bus(bus));
`endif
   initial clk = 1'b0;
   always #5 clk = ~clk;
   function automatic logic [31:0] memf(input logic [31:0] a);
      return a ^ 32'h5A5A_1234;
   endfunction
   // SRAM model: one-cycle read latency
   always @(posedge clk)
      if (bus.sram_en && bus.sram_we == 4'h0) bus.sram_rdata <= memf(bus.sram_addr);
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask
   function automatic vec_t mk(input logic r, input logic ie, input logic [31:0] ia, input logic fl,
                               input logic de, input logic [3:0] we, input logic [31:0] da,
                               input logic [1:0] gnt, input logic sif, input logic smem);
      vec_t v;
      v.rst = r; v.ie = ie; v.ia = ia; v.fl = fl; v.de = de; v.we = we; v.da = da;
      v.gnt = gnt; v.sif = sif; v.smem = smem;
      return v;
   endfunction
   task automatic step(input vec_t v);
      logic [31:0] wd, ea, e;
      logic ev;
      @(posedge clk); #1;
      wd = v.da ^ 32'hFFFF_0000;
      rst = v.rst;
      bus.inst_req_en = v.ie; bus.inst_req_addr = v.ia; bus.inst_flush = v.fl;
      bus.data_req_en = v.de; bus.data_we = v.we; bus.data_addr = v.da; bus.data_wdata = wd;
      @(negedge clk);
      ea = v.gnt == 2'd1 ? v.ia : v.gnt == 2'd2 ? v.da : 32'd0;
      chk("sram_en", {31'd0, bus.sram_en}, {31'd0, v.gnt != 2'd0});
      chk("sram_addr", bus.sram_addr, ea);
      chk("sram_we", {28'd0, bus.sram_we}, {28'd0, v.gnt == 2'd2 ? v.we : 4'h0});
      chk("sram_wdata", bus.sram_wdata, v.gnt == 2'd2 ? wd : 32'd0);
      chk("stallreq_if", {31'd0, bus.stallreq_if}, {31'd0, v.sif});
      chk("stallreq_mem", {31'd0, bus.stallreq_mem}, {31'd0, v.smem});
      ev = 1'b0; e = 32'd0;
      if (iq.size() > 0) begin e = iq.pop_front(); ev = !v.fl && !v.rst; end
      chk("inst_rvalid", {31'd0, bus.inst_rvalid}, {31'd0, ev});
      if (ev) last_i = e;
      if (!v.rst) chk("inst_rdata", bus.inst_rdata, last_i);
      ev = 1'b0;
      if (dq.size() > 0) begin e = dq.pop_front(); ev = !v.rst; end
      chk("data_rvalid", {31'd0, bus.data_rvalid}, {31'd0, ev});
      if (ev) last_d = e;
      if (!v.rst) chk("data_rdata", bus.data_rdata, last_d);
      if (v.rst) begin
         last_i = 32'd0; last_d = 32'd0; confl = 0;
         iq.delete(); dq.delete();
      end else begin
         if (v.gnt == 2'd1) iq.push_back(memf(v.ia));
         if (v.gnt == 2'd2 && v.we == 4'h0) dq.push_back(memf(v.da));
         if (v.ie && !v.fl && v.de) confl++;
      end
   endtask
   initial begin
      passed = 0; total = 0; confl = 0; last_i = 0; last_d = 0;
      rst = 1'b1;
      bus.inst_req_en = 0; bus.inst_req_addr = 0; bus.inst_flush = 0;
      bus.data_req_en = 0; bus.data_we = 0; bus.data_addr = 0; bus.data_wdata = 0;
      bus.sram_rdata = 0;
      vt.push_back(mk(1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
      vt.push_back(mk(1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
      vt.push_back(mk(0, 1, 32'h8000_0000, 0, 0, 4'h0, 0, 1, 0, 0));
      vt.push_back(mk(0, 1, 32'h8000_0004, 0, 0, 4'h0, 0, 1, 0, 0));
      vt.push_back(mk(0, 1, 32'h8000_0008, 0, 0, 4'h0, 0, 1, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
      vt.push_back(mk(0, 1, 32'h8000_0010, 0, 1, 4'h0, 32'h1000, 2, 1, 0));
      vt.push_back(mk(0, 1, 32'h8000_0010, 0, 0, 4'h0, 0, 1, 0, 0));
      for (int i = 0; i < 4; i++)
         vt.push_back(mk(0, 1, 32'h8000_0020, 0, 1, 4'hF, 32'h2000 + 32'(4 * i), 2, 1, 0));
      vt.push_back(mk(0, 1, 32'h8000_0020, 0, 1, 4'hF, 32'h2010, 1, 0, 1));
      vt.push_back(mk(0, 1, 32'h8000_0024, 0, 1, 4'hF, 32'h2010, 2, 1, 0));
      vt.push_back(mk(0, 1, 32'h8000_0030, 0, 0, 4'h0, 0, 1, 0, 0));
      vt.push_back(mk(0, 1, 32'h8000_0034, 1, 0, 4'h0, 0, 0, 0, 0));
      vt.push_back(mk(0, 1, 32'h8000_0034, 1, 1, 4'h0, 32'h3000, 2, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
      foreach (vt[i]) step(vt[i]);
      // starvation builds, a read is in flight when reset hits, then the count restarts from zero
      step(mk(0, 1, 32'h9000_0000, 0, 1, 4'h0, 32'h4000, 2, 1, 0));
      step(mk(0, 1, 32'h9000_0000, 0, 1, 4'h0, 32'h4004, 2, 1, 0));
      step(mk(1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
      for (int i = 0; i < 4; i++)
         step(mk(0, 1, 32'h9000_0100, 0, 1, 4'h0, 32'h5000 + 32'(4 * i), 2, 1, 0));
      step(mk(0, 1, 32'h9000_0100, 0, 1, 4'h0, 32'h5010, 1, 0, 1));
      step(mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
      step(mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
`ifdef SRAM_ARB_PERF_EN
      chk("perf_conflicts", pc, 32'(confl));
      chk("perf_stall_sum", pi + pm, 32'(confl));
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM between the instruction-fetch requester (IF stage) and the data requester (MEM stage).
- Grants one requester per cycle and routes the 1-cycle-latency read data back to the owner.
- Raises per-stage stall requests toward the pipeline stall controller.
- Guarantees forward progress for fetch with a bounded-starvation counter.

Parameters:
- ADDR_W, 32, address width of requesters and SRAM
- DATA_W, 32, data width; DATA_W/8 byte write enables
- STARVE_MAX, 4, consecutive fetch denials tolerated before fetch wins a conflict; legal range 1..15

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- inst_req_en  in  1  fetch read request; held stable while stallreq_if=1
- inst_req_addr  in  ADDR_W  fetch address
- inst_flush  in  1  branch taken; kills the current and the outstanding fetch
- inst_rdata  out  DATA_W  fetch read data
- inst_rvalid  out  1  fetch data valid pulse
- data_req_en  in  1  data access request; held stable while stallreq_mem=1
- data_we  in  DATA_W/8  byte write enables; all-zero means read
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  write data
- data_rdata  out  DATA_W  load data
- data_rvalid  out  1  load data valid pulse
- sram_en  out  1  SRAM enable
- sram_we  out  DATA_W/8  SRAM byte write enables
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after an enabled read
- stallreq_if  out  1  fetch lost arbitration this cycle
- stallreq_mem  out  1  data lost arbitration this cycle

Behaviour:
- Reset (rst=1 at posedge):
  - owner_q=OWN_NONE; starve_cnt=0.
  - inst_rvalid and data_rvalid=0; rdata outputs=0.
  - Stall outputs are combinational from requests.
  - A read outstanding when rst asserts is dropped; no rvalid follows.
- Arbitration (combinational, cycle N):
  - Effective fetch request = inst_req_en & ~inst_flush.
  - Only one requester active: that requester is granted.
  - Both active and starve_cnt<STARVE_MAX: data wins; stallreq_if=1.
  - Both active and starve_cnt==STARVE_MAX: fetch wins; stallreq_mem=1.
  - Neither active: sram_en=0; sram_we, sram_addr, sram_wdata=0.
  - Granted requester drives sram_en=1 and sram_addr. Fetch drives sram_we=0; data drives data_we and data_wdata.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) when fetch is denied.
  - Cleared when fetch is granted or the effective fetch request is low.
- owner_q (next cycle):
  - OWN_I for a granted fetch.
  - OWN_D for a granted data read (data_we==0).
  - Otherwise OWN_NONE. Writes complete at grant and produce no rvalid.
- Response, cycle N+1:
  - owner_q==OWN_I and no inst_flush in N+1: inst_rvalid=1, inst_rdata=sram_rdata.
  - owner_q==OWN_D: data_rvalid=1, data_rdata=sram_rdata.
  - rdata outputs hold their last value when rvalid=0.
- Flush:
  - inst_flush in N+1 suppresses the N+1 fetch response.
  - inst_flush in N withdraws the fetch request in N: no grant, no stall.
- Throughput and latency:
  - Back-to-back grants allowed every cycle. Issue of N+1 overlaps the response of N.
  - Read latency is exactly 1 cycle from grant to rvalid.

Optional Feature:
- Macro: SRAM_ARB_PERF_EN.
- Defined:
  - Adds 32-bit saturating counters perf_conflicts, perf_if_stalls and perf_mem_stalls.
  - Counters clear on rst.
  - Exposed as output ports perf_conflicts, perf_if_stalls and perf_mem_stalls.
- Undefined: counters and ports are absent; functional behaviour is identical.

Decomposition:
- Package sram_arb_pkg holds:
  - owner enum OWN_NONE/OWN_I/OWN_D (2 bits).
  - Default width constants ADDR_W and DATA_W.
- Sub-module sram_arb_perf: the three saturating counters, instantiated only under SRAM_ARB_PERF_EN.
- Grant logic and response routing stay inline.

Test Plan:
- Fetch-only stream, addresses 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles -> sram_en=1 each cycle; inst_rvalid=1 one cycle later with matching data; no stalls.
- Fetch and data load conflict in cycle N, data_addr=0x1000 -> sram_addr=0x1000, stallreq_if=1. N+1: data_rvalid=1; fetch retried and granted.
- Data store (data_we=4'hF) conflicts with fetch for 6 cycles, STARVE_MAX=4 -> data wins 4 times. 5th conflict: fetch wins, stallreq_mem=1, starve_cnt clears. Stores produce no data_rvalid.
- Fetch granted in N, inst_flush=1 in N+1 -> inst_rvalid=0 in N+1. Fetch with inst_flush in the same cycle -> sram_en=0, stallreq_if=0.
- rst=1 in the cycle after a data-read grant -> data_rvalid=0. Post-reset, first requests are arbitrated with starve_cnt=0.
- With SRAM_ARB_PERF_EN: 3 conflicts -> perf_conflicts=3; the sum of perf_if_stalls and perf_mem_stalls is 3.
